// File: rtl/regfile_vec_masked.sv
// Vector register file: REGS x LANES x N bits, three combinational read ports, one masked
// synchronous write port, optional write-to-read bypass and a sequential zeroing sweep.
module regfile_vec_masked #(
  parameter int N      = 20,
  parameter int LANES  = 8,
  parameter int REGS   = 16,
  parameter int AW     = $clog2(REGS),
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [LANES-1:0]     wmask,
  input  logic [LANES*N-1:0]   wd,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  input  logic [AW-1:0]        ra3,
  output logic [LANES*N-1:0]   rd1,
  output logic [LANES*N-1:0]   rd2,
  output logic [LANES*N-1:0]   rd3,
  input  logic                 clr_req,
  output logic                 ready
);

  typedef enum logic {SWEEP, IDLE} state_t;

  localparam logic [AW-1:0] LAST = AW'(REGS - 1);

  state_t                  state, state_n;
  logic [AW-1:0]           ptr, ptr_n;
  logic                    ready_n;
  logic                    sweep_wr;
  logic                    wr_en;

  logic [LANES-1:0][N-1:0] mem [REGS];
  logic [LANES-1:0][N-1:0] wd_lanes;

  logic [AW-1:0]           ra [3];
  logic [2:0]              ra_ok;
  logic                    wa_ok;
  logic [LANES-1:0][N-1:0] rd_v [3];

  assign wd_lanes = wd;
  assign ra[0]    = ra1;
  assign ra[1]    = ra2;
  assign ra[2]    = ra3;

  // Addresses beyond REGS exist only when REGS is not a power of two.
  generate
    if (REGS == (1 << AW)) begin : g_full_range
      assign wa_ok = 1'b1;
      assign ra_ok = 3'b111;
    end else begin : g_part_range
      assign wa_ok = (wa < AW'(REGS));
      for (genvar k = 0; k < 3; k++) begin : g_ra_ok
        assign ra_ok[k] = (ra[k] < AW'(REGS));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SWEEP;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      ready <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    ready_n  = ready;
    sweep_wr = 1'b0;
    wr_en    = 1'b0;
    case (state)
      SWEEP: begin
        sweep_wr = !reset;
        if (ptr == LAST) begin
          state_n = IDLE;
          ready_n = 1'b1;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr + AW'(1);
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_n = SWEEP;
          ptr_n   = '0;
          ready_n = 1'b0;
        end else begin
          wr_en = !reset && we && wa_ok;
        end
      end
      default: begin
        state_n = SWEEP;
        ptr_n   = '0;
        ready_n = 1'b0;
      end
    endcase
  end

  // Storage has no reset; the sweep is the only thing that clears it.
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[wa][i] <= wd_lanes[i];
      end
    end
  end

  generate
    for (genvar k = 0; k < 3; k++) begin : g_read
      always_comb begin
        rd_v[k] = '0;
        if (!reset && state == IDLE && ra_ok[k]) begin
          rd_v[k] = mem[ra[k]];
          if ((BYPASS != 0) && we && !clr_req && wa_ok && ra[k] == wa) begin
            for (int i = 0; i < LANES; i++) begin
              if (wmask[i]) rd_v[k][i] = wd_lanes[i];
            end
          end
        end
      end
    end
  endgenerate

  assign rd1 = rd_v[0];
  assign rd2 = rd_v[1];
  assign rd3 = rd_v[2];

endmodule
